button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 34 +++
 rtl/button_conditioner_if.sv | 28 ++
 rtl/btn_debounce_cell.sv | 78 +++++++
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner block.
//   NUM_KEYS        : number of conditioned buttons
//   KEY_*           : bit positions of each button in the key vectors
//   NUM_REPEAT_KEYS : low-order keys (directions) eligible for auto-repeat
//   FUNC_COUNT      : number of selectable functions
//   func_index_t    : encoding of the current function (0..FUNC_COUNT-1)
//   next_func()     : wrap-around step of the function index
package btn_pkg;

  localparam int unsigned NUM_KEYS        = 9;
  localparam int unsigned NUM_REPEAT_KEYS = 4;
  localparam int unsigned FUNC_COUNT      = 3;

  localparam int unsigned KEY_EAST  = 0;
  localparam int unsigned KEY_WEST  = 1;
  localparam int unsigned KEY_NORTH = 2;
  localparam int unsigned KEY_SOUTH = 3;
  localparam int unsigned KEY_SW0   = 4;
  localparam int unsigned KEY_SW1   = 5;
  localparam int unsigned KEY_SW2   = 6;
  localparam int unsigned KEY_SW3   = 7;
  localparam int unsigned KEY_FUNC  = 8;

  typedef logic [1:0] func_index_t;

  // Explicit wrap so the unused encoding 3 can never be produced.
  function automatic func_index_t next_func(input func_index_t cur);
    if (cur == func_index_t'(FUNC_COUNT - 1)) begin
      return '0;
    end
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between the button conditioner and its user.
//   keys_raw     : raw asynchronous buttons (driven by master)
//   keys_level   : debounced level per key
//   keys_press   : one-cycle press pulse per key (plus auto-repeat pulses)
//   keys_release : one-cycle release pulse per key
//   func_index   : current function, 0..2
//   func_reset   : one-cycle pulse on every function change
// master = the board/user side, slave = the conditioner.
interface button_conditioner_if;
  import btn_pkg::*;

  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] keys_level;
  logic [NUM_KEYS-1:0] keys_press;
  logic [NUM_KEYS-1:0] keys_release;
  func_index_t         func_index;
  logic                func_reset;

  modport master (
    output keys_raw,
    input  keys_level, keys_press, keys_release, func_index, func_reset
  );

  modport slave (
    input  keys_raw,
    output keys_level, keys_press, keys_release, func_index, func_reset
  );
endinterface

// File: rtl/btn_debounce_cell.sv
// Single-key conditioner: 2-flop synchronizer, stability counter, debounced
// level and one-cycle press/release pulses.
//   sysclk      : clock (rising edge)
//   rst         : synchronous active-high reset
//   key_raw     : asynchronous raw button
//   key_level   : debounced level
//   key_press   : high on the first cycle key_level reads 1
//   key_release : high on the first cycle key_level reads 0
// A level change is accepted after DEBOUNCE_CYCLES consecutive cycles of
// mismatch between the synchronized input and the current level.
module btn_debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    // Counter only advances on mismatch; any agreeing cycle restarts it.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: one debounce cell per key, a function selector
// stepped by the function key, and optional auto-repeat on direction keys.
//   sysclk : clock (rising edge)
//   rst    : synchronous active-high reset, dominant over all events
//   bus    : button_conditioner_if.slave (raw keys in, conditioned keys out)
// Optional feature: define BTN_AUTOREPEAT_EN to make keys 0..3 emit extra
// press pulses while held (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles). Without it, press pulses come only from debounced
// rising edges.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 sysclk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] edge_press_w;
  logic [NUM_KEYS-1:0] release_w;
  logic [NUM_KEYS-1:0] repeat_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .sysclk      (sysclk),
      .rst         (rst),
      .key_raw     (bus.keys_raw[i]),
      .key_level   (level_w[i]),
      .key_press   (edge_press_w[i]),
      .key_release (release_w[i])
    );
  end

  // Function selector: updates on the cycle after the function key's press
  // pulse, with func_reset marking that same cycle. Only the debounced edge
  // is used since the function key never repeats.
  func_index_t func_q, func_d;
  logic        func_reset_q, func_reset_d;

  always_comb begin
    func_d       = func_q;
    func_reset_d = 1'b0;
    if (edge_press_w[KEY_FUNC]) begin
      func_d       = next_func(func_q);
      func_reset_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      func_q       <= '0;
      func_reset_q <= 1'b1;
    end else begin
      func_q       <= func_d;
      func_reset_q <= func_reset_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W = $clog2((REP_MAX < 2) ? 2 : REP_MAX);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  // rep_cnt counts cycles since the last press pulse (edge or repeat) of a
  // held key; it reads 0 on the press-pulse cycle itself. rep_periodic
  // selects the shorter period once the first repeat has fired.
  logic [REP_W-1:0]           rep_cnt_q [NUM_REPEAT_KEYS];
  logic [REP_W-1:0]           rep_cnt_d [NUM_REPEAT_KEYS];
  logic [NUM_REPEAT_KEYS-1:0] rep_periodic_q, rep_periodic_d;
  logic [NUM_REPEAT_KEYS-1:0] rep_pulse_q, rep_pulse_d;

  always_comb begin
    for (int i = 0; i < NUM_REPEAT_KEYS; i++) begin
      rep_cnt_d[i]      = '0;
      rep_periodic_d[i] = 1'b0;
      rep_pulse_d[i]    = 1'b0;
      if (level_w[i]) begin
        if (rep_cnt_q[i] == (rep_periodic_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          rep_pulse_d[i]    = 1'b1;
          rep_periodic_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i]      = rep_cnt_q[i] + 1'b1;
          rep_periodic_d[i] = rep_periodic_q[i];
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REPEAT_KEYS; i++) begin
        rep_cnt_q[i] <= '0;
      end
      rep_periodic_q <= '0;
      rep_pulse_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_REPEAT_KEYS; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
      rep_periodic_q <= rep_periodic_d;
      rep_pulse_q    <= rep_pulse_d;
    end
  end

  // Masking with the level drops a pending repeat on the release cycle.
  assign repeat_w = {{(NUM_KEYS - NUM_REPEAT_KEYS){1'b0}},
                     rep_pulse_q & level_w[NUM_REPEAT_KEYS-1:0]};
`else
  assign repeat_w = '0;
`endif

  assign bus.keys_level   = level_w;
  assign bus.keys_press   = edge_press_w | repeat_w;
  assign bus.keys_release = release_w;
  assign bus.func_index   = func_q;
  assign bus.func_reset   = func_reset_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow the build's
// BTN_AUTOREPEAT_EN setting. Inputs change and outputs are sampled on the
// falling clock edge; "cycle k" means k rising edges after the input change.
module tb_button_conditioner;
  import btn_pkg::*;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .sysclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full debounced press/release of the function key, expecting the
  // index to step from prev to nxt one cycle after the press pulse.
  task automatic func_press(input func_index_t prev, input func_index_t nxt);
    bus.keys_raw[KEY_FUNC] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("func_press_k%0d", k), 32'(bus.keys_press[KEY_FUNC]),
            32'(k == 6));
    end
    check("func_hold_idx", 32'(bus.func_index), 32'(prev));
    check("func_hold_rst", 32'(bus.func_reset), 32'd0);
    step();
    check("func_new_idx", 32'(bus.func_index), 32'(nxt));
    check("func_new_rst", 32'(bus.func_reset), 32'd1);
    step();
    check("func_after_rst", 32'(bus.func_reset), 32'd0);
    bus.keys_raw[KEY_FUNC] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("func_rel_k%0d", k), 32'(bus.keys_release[KEY_FUNC]),
            32'(k == 6));
    end
    check("func_stable_idx", 32'(bus.func_index), 32'(nxt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.keys_raw = '0;

    // Reset state.
    step(); step(); step();
    check("rst_level",   32'(bus.keys_level),   32'd0);
    check("rst_press",   32'(bus.keys_press),   32'd0);
    check("rst_release", 32'(bus.keys_release), 32'd0);
    check("rst_func",    32'(bus.func_index),   32'd0);
    check("rst_freset",  32'(bus.func_reset),   32'd1);
    rst = 1'b0;
    step();
    check("post_rst_freset", 32'(bus.func_reset), 32'd0);
    check("post_rst_func",   32'(bus.func_index), 32'd0);

    // East pressed and held: level/press at cycle 6; with auto-repeat,
    // extra pulses at 16, 19, 22.
    bus.keys_raw[KEY_EAST] = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      step();
      check($sformatf("east_level_k%0d", k), 32'(bus.keys_level),
            32'(k >= 6));
      check($sformatf("east_press_k%0d", k), 32'(bus.keys_press),
            32'((k == 6) || (AR && (k == 16 || k == 19 || k == 22))));
    end
    // Release: repeats at 25 and 28 still fall while level is high.
    bus.keys_raw[KEY_EAST] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      check($sformatf("east_rel_k%0d", j), 32'(bus.keys_release),
            32'(j == 6));
      check($sformatf("east_rel_press_k%0d", j), 32'(bus.keys_press),
            32'(AR && (j == 2 || j == 5)));
      check($sformatf("east_rel_level_k%0d", j), 32'(bus.keys_level),
            32'(j < 6));
    end

    // West glitch of 3 cycles is rejected.
    bus.keys_raw[KEY_WEST] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) bus.keys_raw[KEY_WEST] = 1'b0;
      check($sformatf("glitch_level_k%0d", k), 32'(bus.keys_level), 32'd0);
      check($sformatf("glitch_press_k%0d", k), 32'(bus.keys_press), 32'd0);
      check($sformatf("glitch_rel_k%0d", k), 32'(bus.keys_release), 32'd0);
    end

    // Function key cycles 0 -> 1 -> 2 -> 0.
    func_press(2'd0, 2'd1);
    func_press(2'd1, 2'd2);
    func_press(2'd2, 2'd0);

    // Reset mid-debounce with func_index=2 and South held.
    func_press(2'd0, 2'd1);
    func_press(2'd1, 2'd2);
    bus.keys_raw[KEY_SOUTH] = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("mid_rst_level_k%0d", k), 32'(bus.keys_level), 32'd0);
      check($sformatf("mid_rst_press_k%0d", k), 32'(bus.keys_press), 32'd0);
      check($sformatf("mid_rst_rel_k%0d", k), 32'(bus.keys_release), 32'd0);
      check($sformatf("mid_rst_func_k%0d", k), 32'(bus.func_index), 32'd0);
      check($sformatf("mid_rst_freset_k%0d", k), 32'(bus.func_reset), 32'd1);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("south_press_k%0d", k), 32'(bus.keys_press),
            32'(k == 6) << KEY_SOUTH);
      check($sformatf("south_freset_k%0d", k), 32'(bus.func_reset), 32'd0);
      check($sformatf("south_func_k%0d", k), 32'(bus.func_index), 32'd0);
    end
    bus.keys_raw[KEY_SOUTH] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("south_rel_k%0d", k), 32'(bus.keys_release),
            32'(k == 6) << KEY_SOUTH);
    end

    // East and SW1 together: simultaneous press and release pulses.
    bus.keys_raw[KEY_EAST] = 1'b1;
    bus.keys_raw[KEY_SW1]  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("dual_press_k%0d", k), 32'(bus.keys_press),
            (k == 6) ? 32'h021 : 32'h0);
    end
    bus.keys_raw[KEY_EAST] = 1'b0;
    bus.keys_raw[KEY_SW1]  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("dual_rel_k%0d", k), 32'(bus.keys_release),
            (k == 6) ? 32'h021 : 32'h0);
      check($sformatf("dual_rel_press_k%0d", k), 32'(bus.keys_press), 32'd0);
    end
    check("final_level", 32'(bus.keys_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
